// File: rtl/canary_pkg.sv
// Shared types and default qualification constants for the Canary PLL lock logic.
package canary_pkg;

    typedef enum logic [1:0] {
        LOCK_RESET   = 2'd0,
        FREQ_SEARCH  = 2'd1,
        FREQ_LOCKED  = 2'd2,
        PHASE_LOCKED = 2'd3
    } lock_state_t;

    localparam int DEF_STARTUP_CYCLES     = 16;
    localparam int DEF_FREQ_TOL           = 1;
    localparam int DEF_FREQ_LOCK_COUNT    = 8;
    localparam int DEF_PHASE_WIN          = 16;
    localparam int DEF_PHASE_TOL          = 4;
    localparam int DEF_PHASE_LOCK_WINDOWS = 4;
    localparam int DEF_MISS_LIMIT         = 2;

    function automatic logic is_freq_locked(input lock_state_t s);
        return (s == FREQ_LOCKED) || (s == PHASE_LOCKED);
    endfunction

endpackage

// File: rtl/lock_phase_window.sv
// Accumulates bang-bang early/late decisions over fixed-size windows and
// grades each completed window against the phase tolerance.
module lock_phase_window
    import canary_pkg::*;
#(
    parameter int PHASE_WIN = DEF_PHASE_WIN,
    parameter int PHASE_TOL = DEF_PHASE_TOL
) (
    input  logic refclk,
    input  logic reset,
    input  logic clear,
    input  logic pd_valid,
    input  logic pd_early,
    output logic win_done,
    output logic win_good
);

    localparam int AW = $clog2(PHASE_WIN) + 2;
    localparam int NW = $clog2(PHASE_WIN + 1);
    localparam logic [NW-1:0]        LAST_SAMPLE = NW'(PHASE_WIN - 1);
    localparam logic signed [AW-1:0] TOL_W       = AW'(PHASE_TOL);

    logic signed [AW-1:0] acc_reg;
    logic signed [AW-1:0] step;
    logic signed [AW-1:0] sum_next;
    logic signed [AW-1:0] sum_abs;
    logic [NW-1:0]        cnt_reg;
    logic                 win_done_reg;
    logic                 win_good_reg;

    assign step     = pd_early ? AW'(1) : {AW{1'b1}};
    assign sum_next = acc_reg + step;
    assign sum_abs  = sum_next[AW-1] ? -sum_next : sum_next;

    always_ff @(posedge refclk) begin
        if (reset || clear) begin
            acc_reg      <= '0;
            cnt_reg      <= '0;
            win_done_reg <= 1'b0;
            win_good_reg <= 1'b0;
        end else begin
            win_done_reg <= 1'b0;
            if (pd_valid) begin
                // The closing sample is graded together with the running sum.
                if (cnt_reg == LAST_SAMPLE) begin
                    acc_reg      <= '0;
                    cnt_reg      <= '0;
                    win_done_reg <= 1'b1;
                    win_good_reg <= (sum_abs <= TOL_W);
                end else begin
                    acc_reg <= sum_next;
                    cnt_reg <= cnt_reg + NW'(1);
                end
            end
        end
    end

    assign win_done = win_done_reg;
    assign win_good = win_good_reg;

endmodule

// File: rtl/lock_detector.sv
// Refclk-domain lock qualification: frequency streak, phase windows, loss
// detection and a saturating time-to-first-lock counter.
module lock_detector
    import canary_pkg::*;
#(
    parameter int CW                 = 8,
    parameter int DW                 = 8,
    parameter int STARTUP_CYCLES     = DEF_STARTUP_CYCLES,
    parameter int FREQ_TOL           = DEF_FREQ_TOL,
    parameter int FREQ_LOCK_COUNT    = DEF_FREQ_LOCK_COUNT,
    parameter int PHASE_WIN          = DEF_PHASE_WIN,
    parameter int PHASE_TOL          = DEF_PHASE_TOL,
    parameter int PHASE_LOCK_WINDOWS = DEF_PHASE_LOCK_WINDOWS,
    parameter int MISS_LIMIT         = DEF_MISS_LIMIT,
    parameter int LTW                = 16
) (
    input  logic            refclk,
    input  logic            reset,
    input  logic [DW-1:0]   divn,
    input  logic            brake,
    input  logic            fb_valid,
    input  logic [CW-1:0]   fb_count,
    input  logic            pd_valid,
    input  logic            pd_early,
    output lock_state_t     lock_state,
    output logic            lost_lock,
    output logic [LTW-1:0]  lock_cycles
);

    localparam int MW  = ((CW > DW) ? CW : DW) + 1;
    localparam int SUW = $clog2(STARTUP_CYCLES + 1);
    localparam int STW = $clog2(FREQ_LOCK_COUNT + 1);
    localparam int GW  = $clog2(PHASE_LOCK_WINDOWS + 1);
    localparam int MSW = $clog2(MISS_LIMIT + 1);

    localparam logic [SUW-1:0]       STARTUP_LAST = SUW'(STARTUP_CYCLES - 1);
    localparam logic [STW-1:0]       STREAK_DONE  = STW'(FREQ_LOCK_COUNT);
    localparam logic [GW-1:0]        GOOD_DONE    = GW'(PHASE_LOCK_WINDOWS);
    localparam logic [MSW-1:0]       MISS_DONE    = MSW'(MISS_LIMIT);
    localparam logic signed [MW-1:0] FREQ_TOL_W   = MW'(FREQ_TOL);
    localparam logic [LTW-1:0]       CYCLES_MAX   = '1;

    lock_state_t          state_reg, state_next;
    logic [SUW-1:0]       startup_reg, startup_next;
    logic [STW-1:0]       streak_reg, streak_next, streak_inc;
    logic [GW-1:0]        good_reg, good_next, good_inc;
    logic [MSW-1:0]       misses_reg, misses_next, misses_inc;
    logic [DW-1:0]        divn_q_reg;
    logic                 lost_lock_reg, lost_lock_next;
    logic [LTW-1:0]       lock_cycles_reg, lock_cycles_next;
    logic                 frozen_reg, frozen_next;
    logic signed [MW-1:0] freq_err, freq_err_abs;
    logic                 fb_hit, fb_miss;
    logic                 win_clear, win_done, win_good;

    // One extra bit keeps the difference exact for any divn/fb_count pair.
    assign freq_err     = $signed(MW'(fb_count)) - $signed(MW'(divn));
    assign freq_err_abs = freq_err[MW-1] ? -freq_err : freq_err;
    assign fb_hit       = fb_valid && (freq_err_abs <= FREQ_TOL_W);
    assign fb_miss      = fb_valid && !fb_hit;

    assign streak_inc = streak_reg + STW'(1);
    assign good_inc   = good_reg + GW'(1);
    assign misses_inc = misses_reg + MSW'(1);

    // Only samples taken while frequency lock holds across the edge are windowed.
    assign win_clear = !(is_freq_locked(state_reg) && is_freq_locked(state_next));

    lock_phase_window #(
        .PHASE_WIN (PHASE_WIN),
        .PHASE_TOL (PHASE_TOL)
    ) u_window (
        .refclk   (refclk),
        .reset    (reset),
        .clear    (win_clear),
        .pd_valid (pd_valid),
        .pd_early (pd_early),
        .win_done (win_done),
        .win_good (win_good)
    );

    always_comb begin
        state_next   = state_reg;
        startup_next = startup_reg;
        streak_next  = streak_reg;
        good_next    = good_reg;
        misses_next  = misses_reg;
        if (state_reg == LOCK_RESET) begin
            if (startup_reg == STARTUP_LAST) begin
                state_next = FREQ_SEARCH;
            end else begin
                startup_next = startup_reg + SUW'(1);
            end
        end else if (brake || (divn != divn_q_reg)) begin
            state_next  = FREQ_SEARCH;
            streak_next = '0;
            good_next   = '0;
            misses_next = '0;
        end else begin
            case (state_reg)
                FREQ_SEARCH: begin
                    if (fb_hit) begin
                        if (streak_inc == STREAK_DONE) begin
                            state_next  = FREQ_LOCKED;
                            streak_next = '0;
                            good_next   = '0;
                        end else begin
                            streak_next = streak_inc;
                        end
                    end else if (fb_miss) begin
                        streak_next = '0;
                    end
                end
                FREQ_LOCKED: begin
                    // A frequency miss outranks any window result in the same cycle.
                    if (fb_miss) begin
                        state_next = FREQ_SEARCH;
                        good_next  = '0;
                    end else if (win_done) begin
                        if (!win_good) begin
                            good_next = '0;
                        end else if (good_inc == GOOD_DONE) begin
                            state_next = PHASE_LOCKED;
                            good_next  = '0;
                        end else begin
                            good_next = good_inc;
                        end
                    end
                end
                PHASE_LOCKED: begin
                    if (fb_miss) begin
                        if (misses_inc == MISS_DONE) begin
                            state_next  = FREQ_SEARCH;
                            misses_next = '0;
                        end else begin
                            misses_next = misses_inc;
                        end
                    end else if (win_done && !win_good) begin
                        state_next  = FREQ_LOCKED;
                        misses_next = '0;
                    end else if (fb_hit) begin
                        misses_next = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        lost_lock_next   = (state_reg == PHASE_LOCKED) && (state_next != PHASE_LOCKED);
        frozen_next      = frozen_reg || (state_next == PHASE_LOCKED);
        lock_cycles_next = lock_cycles_reg;
        // Both the entry edge into FREQ_SEARCH and the edge reaching PHASE_LOCKED count.
        if (!frozen_reg && ((state_reg != LOCK_RESET) || (state_next != LOCK_RESET))
                && (lock_cycles_reg != CYCLES_MAX)) begin
            lock_cycles_next = lock_cycles_reg + LTW'(1);
        end
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            state_reg       <= LOCK_RESET;
            startup_reg     <= '0;
            streak_reg      <= '0;
            good_reg        <= '0;
            misses_reg      <= '0;
            divn_q_reg      <= divn;
            lost_lock_reg   <= 1'b0;
            lock_cycles_reg <= '0;
            frozen_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            startup_reg     <= startup_next;
            streak_reg      <= streak_next;
            good_reg        <= good_next;
            misses_reg      <= misses_next;
            divn_q_reg      <= divn;
            lost_lock_reg   <= lost_lock_next;
            lock_cycles_reg <= lock_cycles_next;
            frozen_reg      <= frozen_next;
        end
    end

    assign lock_state  = state_reg;
    assign lost_lock   = lost_lock_reg;
    assign lock_cycles = lock_cycles_reg;

endmodule

// File: tb/tb_lock_detector.sv
// Self-checking bench for lock_detector: directed lock scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_lock_detector;
    import canary_pkg::*;

    logic        refclk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  divn = 8'd30;
    logic        brake = 1'b0;
    logic        fb_valid = 1'b0;
    logic [7:0]  fb_count = 8'd0;
    logic        pd_valid = 1'b0;
    logic        pd_early = 1'b0;
    lock_state_t lock_state;
    logic        lost_lock;
    logic [15:0] lock_cycles;

    always #5 refclk = ~refclk;

    lock_detector dut (
        .refclk      (refclk),
        .reset       (reset),
        .divn        (divn),
        .brake       (brake),
        .fb_valid    (fb_valid),
        .fb_count    (fb_count),
        .pd_valid    (pd_valid),
        .pd_early    (pd_early),
        .lock_state  (lock_state),
        .lost_lock   (lost_lock),
        .lock_cycles (lock_cycles)
    );

    int n_compared = 0;
    int n_mismatch = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: counts hits, misses and graded windows as plain integers.
    lock_state_t m_state = LOCK_RESET;
    bit          m_lost = 0;
    int          m_cycles = 0;
    bit          m_frozen = 0;
    int          m_startup = 0;
    int          m_streak = 0;
    int          m_good = 0;
    int          m_misses = 0;
    int          m_divn_prev = 30;
    bit          win_q[$];
    bit          m_evt_valid = 0;
    bit          m_evt_good = 0;
    bit          pd_ph = 0;

    task automatic model_update();
        lock_state_t prev, nxt;
        bit done, good_w, hit, miss, accept;
        int d, early_cnt, sum;
        if (reset) begin
            m_state = LOCK_RESET; m_lost = 0; m_cycles = 0; m_frozen = 0;
            m_startup = 0; m_streak = 0; m_good = 0; m_misses = 0;
            win_q.delete(); m_evt_valid = 0; m_evt_good = 0;
            m_divn_prev = int'(divn);
            return;
        end
        prev   = m_state;
        nxt    = prev;
        done   = m_evt_valid;
        good_w = m_evt_good;
        d      = int'(fb_count) - int'(divn);
        hit    = fb_valid && (d >= -1) && (d <= 1);
        miss   = fb_valid && !hit;
        if (prev == LOCK_RESET) begin
            m_startup++;
            if (m_startup == 16) nxt = FREQ_SEARCH;
        end else if (brake || (int'(divn) != m_divn_prev)) begin
            nxt = FREQ_SEARCH;
            m_streak = 0; m_good = 0; m_misses = 0;
        end else if (prev == FREQ_SEARCH) begin
            if (hit) begin
                m_streak++;
                if (m_streak == 8) nxt = FREQ_LOCKED;
            end else if (miss) begin
                m_streak = 0;
            end
        end else if (prev == FREQ_LOCKED) begin
            if (miss) nxt = FREQ_SEARCH;
            else if (done) begin
                m_good = good_w ? m_good + 1 : 0;
                if (m_good == 4) nxt = PHASE_LOCKED;
            end
        end else begin
            if (miss) begin
                m_misses++;
                if (m_misses == 2) nxt = FREQ_SEARCH;
            end else begin
                if (hit) m_misses = 0;
                if (done && !good_w) nxt = FREQ_LOCKED;
            end
        end
        if (nxt != prev) begin
            m_streak = 0; m_good = 0; m_misses = 0;
        end
        accept = (prev == FREQ_LOCKED || prev == PHASE_LOCKED) &&
                 (nxt == FREQ_LOCKED || nxt == PHASE_LOCKED);
        m_evt_valid = 0;
        if (!accept) begin
            win_q.delete();
        end else if (pd_valid) begin
            win_q.push_back(pd_early);
            if (win_q.size() == 16) begin
                early_cnt = 0;
                for (int k = 0; k < win_q.size(); k++) early_cnt += int'(win_q[k]);
                sum = 2 * early_cnt - 16;
                m_evt_valid = 1;
                m_evt_good = (sum <= 4) && (sum >= -4);
                win_q.delete();
            end
        end
        m_lost = (prev == PHASE_LOCKED) && (nxt != PHASE_LOCKED);
        if (!m_frozen && (prev != LOCK_RESET || nxt != LOCK_RESET) && m_cycles < 65535) m_cycles++;
        if (nxt == PHASE_LOCKED) m_frozen = 1;
        m_state = nxt;
        m_divn_prev = int'(divn);
    endtask

    task automatic tick(input bit rst, input bit fv, input logic [7:0] fc,
                        input bit pv, input bit pe, input bit br);
        reset = rst; fb_valid = fv; fb_count = fc; pd_valid = pv; pd_early = pe; brake = br;
        @(posedge refclk);
        model_update();
        #1;
        check("lock_state", 32'(lock_state), 32'(m_state));
        check("lost_lock", 32'(lost_lock), 32'(m_lost));
        check("lock_cycles", 32'(lock_cycles), 32'(m_cycles));
    endtask

    task automatic ltick(input logic [7:0] fc);
        tick(0, 1, fc, 1, pd_ph, 0);
        pd_ph = ~pd_ph;
    endtask

    task automatic do_reset();
        tick(1, 0, 8'd0, 0, 0, 0);
        tick(1, 0, 8'd0, 0, 0, 0);
        check("reset_state", 32'(lock_state), 32'(LOCK_RESET));
        check("reset_lost", 32'(lost_lock), 32'd0);
        check("reset_cycles", 32'(lock_cycles), 32'd0);
    endtask

    task automatic wait_state(input string tag, input lock_state_t s, input int bound,
                              input bit fv, input logic [7:0] fc, input bit pv);
        int n = 0;
        while (lock_state != s && n < bound) begin
            tick(0, fv, fc, pv, pd_ph, 0);
            pd_ph = ~pd_ph;
            n++;
        end
        check(tag, 32'(lock_state), 32'(s));
    endtask

    task automatic feed_window(input int n_early);
        for (int k = 0; k < 16; k++) tick(0, 1, 8'd30, 1, (k < n_early), 0);
        tick(0, 1, 8'd30, 0, 0, 0);
    endtask

    function automatic logic [7:0] gen_fb(input logic [7:0] dv, input int noise_den);
        int v, off;
        int zero_set[4] = '{0, 1, 2, 255};
        if (dv == 8'd0) return 8'(zero_set[$urandom_range(0, 3)]);
        if ($urandom_range(0, noise_den - 1) != 0) begin
            v = int'(dv) + int'($urandom_range(0, 2)) - 1;
        end else begin
            off = int'($urandom_range(2, 6));
            v = ($urandom_range(0, 1) != 0) ? int'(dv) + off : int'(dv) - off;
        end
        return 8'(v);
    endfunction

    function automatic logic [7:0] pick_divn();
        if ($urandom_range(0, 7) == 0) return 8'd0;
        return 8'($urandom_range(10, 240));
    endfunction

    initial begin
        int t_fs, t_fl, t_pl, n, brake_left, noise_den;
        bit rst, fv, pv, br;

        // Basic lock: exact feedback count, alternating phase decisions.
        divn = 8'd30;
        do_reset();
        t_fs = -1; t_fl = -1; t_pl = -1;
        for (int i = 1; i <= 100; i++) begin
            ltick(8'd30);
            if (t_fs < 0 && lock_state == FREQ_SEARCH) t_fs = i;
            if (t_fl < 0 && lock_state == FREQ_LOCKED) t_fl = i;
            if (t_pl < 0 && lock_state == PHASE_LOCKED) t_pl = i;
        end
        check("t_freq_search", 32'(t_fs), 32'd16);
        check("t_freq_locked", 32'(t_fl), 32'd24);
        check("t_phase_locked", 32'(t_pl), 32'd89);
        check("basic_lock_cycles", 32'(lock_cycles), 32'd74);
        $display("scenario basic_lock: search@%0d flock@%0d plock@%0d lock_cycles=%0d", t_fs, t_fl, t_pl, lock_cycles);

        // Lost lock through consecutive frequency misses.
        ltick(8'd25);
        check("one_miss_state", 32'(lock_state), 32'(PHASE_LOCKED));
        check("one_miss_lost", 32'(lost_lock), 32'd0);
        ltick(8'd30);
        ltick(8'd25);
        ltick(8'd25);
        check("two_miss_state", 32'(lock_state), 32'(FREQ_SEARCH));
        check("two_miss_lost", 32'(lost_lock), 32'd1);
        ltick(8'd30);
        check("lost_pulse_end", 32'(lost_lock), 32'd0);
        $display("scenario miss_loss: state=%0d", lock_state);

        // Lost lock through a biased phase window.
        wait_state("relock_a", PHASE_LOCKED, 300, 1, 8'd30, 1);
        n = 0;
        while (!lost_lock && n < 40) begin
            tick(0, 1, 8'd30, 1, 1, 0);
            n++;
        end
        check("badwin_state", 32'(lock_state), 32'(FREQ_LOCKED));
        check("badwin_lost", 32'(lost_lock), 32'd1);
        check("badwin_cycles_frozen", 32'(lock_cycles), 32'd74);
        $display("scenario bad_window: lost after %0d cycles", n);

        // Brake pulse while locked, then divn change with matching feedback.
        wait_state("relock_b", PHASE_LOCKED, 300, 1, 8'd30, 1);
        tick(0, 1, 8'd30, 1, pd_ph, 1);
        pd_ph = ~pd_ph;
        check("brake_state", 32'(lock_state), 32'(FREQ_SEARCH));
        check("brake_lost", 32'(lost_lock), 32'd1);
        ltick(8'd30);
        check("brake_lost_end", 32'(lost_lock), 32'd0);
        divn = 8'd32;
        wait_state("relock_divn", PHASE_LOCKED, 300, 1, 8'd32, 1);
        check("divn_cycles_frozen", 32'(lock_cycles), 32'd74);
        $display("scenario brake_divn: state=%0d lock_cycles=%0d", lock_state, lock_cycles);

        // Reset while frequency locked.
        tick(0, 1, 8'd32, 1, pd_ph, 1);
        wait_state("mid_flock", FREQ_LOCKED, 30, 1, 8'd32, 0);
        tick(1, 1, 8'd32, 1, pd_ph, 0);
        check("midreset_state", 32'(lock_state), 32'(LOCK_RESET));
        check("midreset_cycles", 32'(lock_cycles), 32'd0);
        check("midreset_lost", 32'(lost_lock), 32'd0);
        $display("scenario reset_mid_lock: state=%0d", lock_state);

        // Tolerance edges.
        divn = 8'd30;
        do_reset();
        wait_state("tol_search", FREQ_SEARCH, 30, 0, 8'd0, 0);
        for (int i = 0; i < 7; i++) tick(0, 1, 8'd31, 0, 0, 0);
        check("tol31_hold", 32'(lock_state), 32'(FREQ_SEARCH));
        tick(0, 1, 8'd31, 0, 0, 0);
        check("tol31_lock", 32'(lock_state), 32'(FREQ_LOCKED));
        do_reset();
        wait_state("tol_search2", FREQ_SEARCH, 30, 0, 8'd0, 0);
        for (int i = 0; i < 40; i++) tick(0, 1, (i % 5 == 4) ? 8'd32 : 8'd30, 0, 0, 0);
        check("tol32_stay", 32'(lock_state), 32'(FREQ_SEARCH));
        $display("scenario tolerance: state=%0d", lock_state);

        // Phase bias windows: 10/6 good, 11/5 bad.
        do_reset();
        wait_state("bias_flock", FREQ_LOCKED, 40, 1, 8'd30, 0);
        feed_window(10); feed_window(10); feed_window(10); feed_window(11);
        check("bias_bad_resets", 32'(lock_state), 32'(FREQ_LOCKED));
        feed_window(10); feed_window(10); feed_window(10);
        check("bias_three_good", 32'(lock_state), 32'(FREQ_LOCKED));
        feed_window(10);
        check("bias_four_good", 32'(lock_state), 32'(PHASE_LOCKED));
        $display("scenario phase_bias: state=%0d", lock_state);

        // Randomized traffic against the model.
        for (int s = 0; s < 8; s++) begin
            divn = (s == 0) ? 8'd0 : pick_divn();
            do_reset();
            noise_den = (s % 3 == 0) ? 128 : ((s % 3 == 1) ? 16 : 4);
            brake_left = 0;
            for (int c = 0; c < 1200; c++) begin
                if ($urandom_range(0, 599) == 0) divn = pick_divn();
                if (brake_left == 0 && $urandom_range(0, 399) == 0) brake_left = int'($urandom_range(1, 4));
                br = (brake_left > 0);
                if (brake_left > 0) brake_left--;
                rst = ($urandom_range(0, 1999) == 0);
                fv = (s % 2 == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                pv = (s % 2 == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                tick(rst, fv, gen_fb(divn, noise_den), pv, pd_ph ^ ($urandom_range(0, 9) == 0), br);
                pd_ph = ~pd_ph;
            end
            $display("scenario random_%0d: divn=%0d state=%0d lock_cycles=%0d", s, divn, lock_state, lock_cycles);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
